nand4_sweep_ctrl: RTL
=====================

Name: nand4_sweep_ctrl

Overview:
- Self-test sequencer for the team's 4-input gate cells, such as four_inp_nand.
- On a start pulse it drives all 16 input vectors onto the gate, holding each for DWELL cycles, and samples the gate output at the end of each dwell.
- Each sample is compared against a programmable 16-bit expected truth table; mismatches are counted and the first failing vector is recorded.
- Replaces hand-written exhaustive stimulus benches and serves as an on-chip BIST for gate cells.

Parameters:
- DWELL, 4, cycles each vector is held; legal range 1..255; the sample is taken in the last dwell cycle.
- CNT_W, 5, width of err_cnt; the count saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  sweep request, sampled only in IDLE.
- expect_tt  in  16  expected output; bit i is the expected y for vector i. NAND is 16'h7FFF. Latched on accepted start.
- gate_y  in  1  output of the gate under test.
- vec_out  out  4  {a,b,c,d} driven to the gate; a is the MSB.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of sweep.
- pass  out  1  high when the last sweep had zero mismatches; held until the next start.
- err_cnt  out  CNT_W  mismatch count of the current or last sweep.
- fail_seen  out  1  at least one mismatch in the current or last sweep.
- first_fail  out  4  vector index of the first mismatch; valid when fail_seen=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; vec_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_seen=0, first_fail=0, dwell counter=0. Reset takes effect immediately, including mid-sweep, and aborts the sweep with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - vec_out=0.
  - start=1 at edge T0: latch expect_tt; clear err_cnt, fail_seen, first_fail, pass; vec=0, dcnt=0, busy=1; go to RUN.
- RUN:
  - dcnt increments each cycle.
  - At the edge where dcnt==DWELL-1, gate_y is sampled and compared to tt[vec].
  - On mismatch: err_cnt+1, saturating. If fail_seen==0, first_fail<=vec and fail_seen<=1.
  - At that same edge: if vec==15, go to DONE; else vec<=vec+1 and dcnt<=0.
  - The sample for vector i occurs at edge T0+(i+1)*DWELL.
- DONE:
  - Entered at edge T0+16*DWELL.
  - done=1 for exactly one cycle; busy=0 and pass=(err_cnt==0) from that same edge.
  - vec_out holds 15.
  - Next edge: IDLE, done=0, vec_out=0.
- start while busy, or in DONE, is ignored and not queued.
- expect_tt changes after latching have no effect on the current sweep.
- DWELL=1: the vector changes every cycle and is sampled in the same cycle, which assumes a purely combinational gate path.
- Sweep latency, start edge to done rising: 16*DWELL cycles.
- All outputs are registered.

Optional Feature:
- Macro: SWEEP_STOP_ON_FAIL_EN.
- Defined:
  - On the first mismatch, the FSM goes RUN->DONE at that sample edge.
  - done pulses, err_cnt=1, fail_seen=1, and vec_out holds the failing vector during DONE.
  - pass=0.
- Undefined: all 16 vectors are always swept, and err_cnt reflects the total mismatch count.

Test Plan:
- Behavioural NAND, expect_tt=16'h7FFF, DWELL=4, start pulse:
  - vec_out steps 0..15, each held 4 cycles.
  - done 64 cycles after the start edge, lasting one cycle.
  - pass=1, err_cnt=0, fail_seen=0.
- gate_y stuck at 1, expect 16'h7FFF: err_cnt=1, first_fail=4'hF, fail_seen=1, pass=0.
- gate_y stuck at 0:
  - Without the macro: err_cnt=15, first_fail=0, done 64 cycles after the start edge.
  - With SWEEP_STOP_ON_FAIL_EN: done 4 cycles after the start edge, err_cnt=1, vec_out=0 during DONE.
- AND model against the NAND table: 16 mismatches. CNT_W=5 gives err_cnt=16; CNT_W=4 saturates at 15.
- Start re-pulsed at vector 5: ignored, with done still at 64 cycles.
- rst_n pulsed low at vector 7: all outputs are 0 immediately and there is no done. A fresh start then completes a full clean sweep.

Source files
------------

// File: rtl/nand4_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nand4_sweep_ctrl
//   Exhaustive self-test sequencer for 4-input gate cells. On an accepted start
//   it drives all 16 input vectors onto the gate under test. Each vector is held
//   for DWELL cycles, and the gate output is sampled in the last dwell cycle.
//   Every sample is compared against a latched 16-bit expected truth table.
//   Mismatches are counted (saturating) and the first failing vector is kept.
//
//   Build option: SWEEP_STOP_ON_FAIL_EN
//     When defined, the sweep ends at the first mismatching sample. DONE then
//     holds the failing vector on vec_out. When undefined, all 16 vectors are
//     always swept.
//
// Parameters
//   DWELL  cycles each vector is held (1..255)
//   CNT_W  width of err_cnt; the count saturates at 2^CNT_W-1
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset; aborts a sweep with no done
//   start       sweep request, honoured only in IDLE
//   expect_tt   expected gate output, bit i for vector i; latched on start
//   gate_y      output of the gate under test
//   vec_out     {a,b,c,d} applied to the gate, a is the MSB
//   busy        high from accepted start until done
//   done        one-cycle pulse at the end of a sweep
//   pass        last sweep had zero mismatches; held until the next start
//   err_cnt     mismatch count of the current or last sweep
//   fail_seen   at least one mismatch in the current or last sweep
//   first_fail  vector index of the first mismatch (valid when fail_seen)
//
// FSM states
//   state | meaning
//   IDLE  | waiting for start, vec_out parked at 0
//   RUN   | stepping vectors, sampling gate_y at the end of each dwell
//   DONE  | one cycle: done pulse, results final, vec_out holds last vector
// -----------------------------------------------------------------------------
module nand4_sweep_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      expect_tt,
  input  logic             gate_y,
  output logic [3:0]       vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [3:0]       first_fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [CNT_W-1:0] ERR_MAX    = '1;
  localparam logic [CNT_W-1:0] ERR_ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [7:0]       dcnt, dcnt_nxt;
  logic [15:0]      tt, tt_nxt;
  logic [3:0]       vec_nxt;
  logic             busy_nxt, done_nxt, pass_nxt, fs_nxt;
  logic [CNT_W-1:0] err_nxt;
  logic [3:0]       ff_nxt;

  logic sample;
  logic mismatch;
  logic stop_now;

  // The sample edge is the last cycle of each dwell window.
  assign sample   = (state == RUN) && (dcnt == DWELL_LAST);
  assign mismatch = sample && (gate_y != tt[vec_out]);

`ifdef SWEEP_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (sample && ((vec_out == 4'hF) || stop_now)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    dcnt_nxt = dcnt;
    tt_nxt   = tt;
    vec_nxt  = vec_out;
    busy_nxt = busy;
    done_nxt = 1'b0;
    pass_nxt = pass;
    err_nxt  = err_cnt;
    fs_nxt   = fail_seen;
    ff_nxt   = first_fail;
    unique case (state)
      IDLE: begin
        vec_nxt = 4'd0;
        if (start) begin
          tt_nxt   = expect_tt;
          err_nxt  = '0;
          fs_nxt   = 1'b0;
          ff_nxt   = 4'd0;
          pass_nxt = 1'b0;
          dcnt_nxt = 8'd0;
          busy_nxt = 1'b1;
        end
      end
      RUN: begin
        dcnt_nxt = dcnt + 8'd1;
        if (mismatch) begin
          if (err_cnt != ERR_MAX) err_nxt = err_cnt + ERR_ONE;
          if (!fail_seen) begin
            fs_nxt = 1'b1;
            ff_nxt = vec_out;
          end
        end
        if (sample) begin
          dcnt_nxt = 8'd0;
          if ((vec_out == 4'hF) || stop_now) begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
            // Include the sample taken on this very edge.
            pass_nxt = !mismatch && (err_cnt == '0);
          end else begin
            vec_nxt = vec_out + 4'd1;
          end
        end
      end
      DONE: vec_nxt = 4'd0;
      default: vec_nxt = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt       <= 8'd0;
      tt         <= 16'd0;
      vec_out    <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_seen  <= 1'b0;
      first_fail <= 4'd0;
    end else begin
      dcnt       <= dcnt_nxt;
      tt         <= tt_nxt;
      vec_out    <= vec_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_cnt    <= err_nxt;
      fail_seen  <= fs_nxt;
      first_fail <= ff_nxt;
    end
  end

endmodule
